regfile_scoreboard: RTL and testbench

Per-thread register file with a load scoreboard, replacing the fixed 8-bit, 16-entry per-thread register file. It is generalised in data width and register count. Loads are deferred: a load marks its destination pending, and the LSU writes the value back later through a dedicated write port. Hazards on pending registers are flagged to the scheduler. It sits in each thread lane of a core, between the decoder/scheduler, the ALU and the LSU.

---
 rtl/regfile_scoreboard.sv | 155 +++++++++++++++
 tb/tb_regfile_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Per-thread register file with a deferred-load scoreboard.
// Top three registers are read-only %blockIdx, %blockDim, %threadIdx.
package states_pkg;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [1:0] MUX_ARITH = 2'b00;
  localparam logic [1:0] MUX_MEM   = 2'b01;
  localparam logic [1:0] MUX_CONST = 2'b10;
endpackage

module regfile_scoreboard
  import states_pkg::*;
#(
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  localparam int ADDR_BITS        = $clog2(NUM_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_block_start,
  input  logic [7:0]           i_block_id,
  input  logic [2:0]           i_core_state,
  input  logic [ADDR_BITS-1:0] i_decoded_rd_address,
  input  logic [ADDR_BITS-1:0] i_decoded_rs_address,
  input  logic [ADDR_BITS-1:0] i_decoded_rt_address,
  input  logic                 i_decoded_reg_write_enable,
  input  logic [1:0]           i_decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] i_decoded_immediate,
  input  logic [DATA_BITS-1:0] i_alu_out,
  input  logic                 i_lsu_wb_valid,
  input  logic [ADDR_BITS-1:0] i_lsu_wb_addr,
  input  logic [DATA_BITS-1:0] i_lsu_wb_data,
  output logic [DATA_BITS-1:0] o_rs,
  output logic [DATA_BITS-1:0] o_rt,
  output logic                 o_hazard,
  output logic [NUM_REGS-1:0]  o_pending,
  output logic                 o_busy,
  output logic                 o_wb_error
);

  localparam int NWR = NUM_REGS - 3;
  localparam logic [ADDR_BITS-1:0] LAST_WR =
    ADDR_BITS'(NUM_REGS - 4);

  logic [DATA_BITS-1:0] r_regs [NWR];
  logic [DATA_BITS-1:0] r_block_idx;
  logic [NUM_REGS-1:0]  r_pending;
  logic [DATA_BITS-1:0] r_rs;
  logic [DATA_BITS-1:0] r_rt;
  logic                 r_hazard;
  logic                 r_wb_error;

  logic [DATA_BITS-1:0] w_view [NUM_REGS];
  logic                 w_wb_ok;
  logic                 w_byp_rs;
  logic                 w_byp_rt;
  logic                 w_byp_rd;
  logic                 w_haz;
  logic                 w_rd_ok;
  logic                 w_req;
  logic                 w_upd;

  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      w_view[i] = r_regs[i];
    end
    w_view[NUM_REGS-3] = r_block_idx;
    w_view[NUM_REGS-2] = DATA_BITS'(THREADS_PER_BLOCK);
    w_view[NUM_REGS-1] = DATA_BITS'(THREAD_ID);
  end

  assign w_req   = (i_core_state == S_REQUEST);
  assign w_upd   = (i_core_state == S_UPDATE);
  assign w_rd_ok = (i_decoded_rd_address <= LAST_WR);

  // Only a writeback that retires an outstanding load is legal
  assign w_wb_ok = i_lsu_wb_valid
                 & (i_lsu_wb_addr <= LAST_WR)
                 & r_pending[i_lsu_wb_addr];

  assign w_byp_rs = w_wb_ok
    & (i_lsu_wb_addr == i_decoded_rs_address);
  assign w_byp_rt = w_wb_ok
    & (i_lsu_wb_addr == i_decoded_rt_address);
  assign w_byp_rd = w_wb_ok
    & (i_lsu_wb_addr == i_decoded_rd_address);

  assign w_haz =
      (r_pending[i_decoded_rs_address] & ~w_byp_rs)
    | (r_pending[i_decoded_rt_address] & ~w_byp_rt)
    | (i_decoded_reg_write_enable
       & r_pending[i_decoded_rd_address] & ~w_byp_rd);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rs     <= '0;
      r_rt     <= '0;
      r_hazard <= 1'b0;
    end else if (i_enable && w_req) begin
      r_rs <= w_byp_rs ? i_lsu_wb_data
                       : w_view[i_decoded_rs_address];
      r_rt <= w_byp_rt ? i_lsu_wb_data
                       : w_view[i_decoded_rt_address];
      r_hazard <= w_haz;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_block_idx <= '0;
    end else if (i_enable && i_block_start) begin
      r_block_idx <= DATA_BITS'(i_block_id);
    end
  end

  // UPDATE is applied after writeback so it wins on a shared address
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NWR; i++) begin
        r_regs[i] <= '0;
      end
      r_pending  <= '0;
      r_wb_error <= 1'b0;
    end else if (i_enable) begin
      if (w_wb_ok) begin
        r_regs[i_lsu_wb_addr]    <= i_lsu_wb_data;
        r_pending[i_lsu_wb_addr] <= 1'b0;
      end else if (i_lsu_wb_valid) begin
        r_wb_error <= 1'b1;
      end
      if (w_upd && i_decoded_reg_write_enable && w_rd_ok) begin
        case (i_decoded_reg_input_mux)
          MUX_ARITH:
            r_regs[i_decoded_rd_address] <= i_alu_out;
          MUX_CONST:
            r_regs[i_decoded_rd_address] <= i_decoded_immediate;
          MUX_MEM:
            r_pending[i_decoded_rd_address] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_rs       = r_rs;
  assign o_rt       = r_rt;
  assign o_hazard   = r_hazard;
  assign o_pending  = r_pending;
  assign o_busy     = |r_pending;
  assign o_wb_error = r_wb_error;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// Expected values are queued at drive time and popped at sample time.
module tb_regfile_scoreboard;

  localparam int DB = 8;
  localparam int NR = 16;
  localparam int AB = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic          i_block_start;
  logic [7:0]    i_block_id;
  logic [2:0]    i_core_state;
  logic [AB-1:0] i_rd, i_rs_a, i_rt_a;
  logic          i_we;
  logic [1:0]    i_mux;
  logic [DB-1:0] i_imm, i_alu;
  logic          i_wb_valid;
  logic [AB-1:0] i_wb_addr;
  logic [DB-1:0] i_wb_data;
  logic [DB-1:0] o_rs, o_rt;
  logic          o_hazard;
  logic [NR-1:0] o_pending;
  logic          o_busy;
  logic          o_wb_error;

  regfile_scoreboard #(
    .DATA_BITS(DB), .NUM_REGS(NR),
    .THREADS_PER_BLOCK(4), .THREAD_ID(2)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_block_start(i_block_start),
    .i_block_id(i_block_id),
    .i_core_state(i_core_state),
    .i_decoded_rd_address(i_rd),
    .i_decoded_rs_address(i_rs_a),
    .i_decoded_rt_address(i_rt_a),
    .i_decoded_reg_write_enable(i_we),
    .i_decoded_reg_input_mux(i_mux),
    .i_decoded_immediate(i_imm),
    .i_alu_out(i_alu),
    .i_lsu_wb_valid(i_wb_valid),
    .i_lsu_wb_addr(i_wb_addr),
    .i_lsu_wb_data(i_wb_data),
    .o_rs(o_rs),
    .o_rt(o_rt),
    .o_hazard(o_hazard),
    .o_pending(o_pending),
    .o_busy(o_busy),
    .o_wb_error(o_wb_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;
  localparam logic [1:0] M_AR = 2'b00;
  localparam logic [1:0] M_MEM = 2'b01;
  localparam logic [1:0] M_CON = 2'b10;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_asrt++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL queue_empty: observed %0h required an entry", obs);
      return;
    end
    e = q.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    i_core_state  = 3'b000;
    i_we          = 1'b0;
    i_wb_valid    = 1'b0;
    i_block_start = 1'b0;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
    idle();
  endtask

  task automatic set_upd(input logic [AB-1:0] rd,
                         input logic [1:0] mux,
                         input logic [DB-1:0] v);
    i_core_state = UPD;
    i_we  = 1'b1;
    i_rd  = rd;
    i_mux = mux;
    i_imm = v;
    i_alu = v;
  endtask

  task automatic set_wb(input logic [AB-1:0] a,
                        input logic [DB-1:0] d);
    i_wb_valid = 1'b1;
    i_wb_addr  = a;
    i_wb_data  = d;
  endtask

  task automatic chk_pend(input string tag,
                          input logic [NR-1:0] e);
    push(tag, {16'b0, e});
    check({16'b0, o_pending});
  endtask

  task automatic chk_err(input string tag, input logic e);
    push(tag, {31'b0, e});
    check({31'b0, o_wb_error});
  endtask

  task automatic req_chk(input string tag,
                         input logic [AB-1:0] rs,
                         input logic [AB-1:0] rt,
                         input logic [AB-1:0] rd,
                         input logic we,
                         input logic [DB-1:0] ers,
                         input logic [DB-1:0] ert,
                         input logic ehz);
    i_core_state = REQ;
    i_rs_a = rs;
    i_rt_a = rt;
    i_rd   = rd;
    i_we   = we;
    push({tag, "_rs"}, {24'b0, ers});
    push({tag, "_rt"}, {24'b0, ert});
    push({tag, "_hz"}, {31'b0, ehz});
    cyc();
    check({24'b0, o_rs});
    check({24'b0, o_rt});
    check({31'b0, o_hazard});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_enable = 1'b1;
    i_block_id = 8'd0;
    i_rd = '0; i_rs_a = '0; i_rt_a = '0;
    i_mux = '0; i_imm = '0; i_alu = '0;
    i_wb_addr = '0; i_wb_data = '0;
    idle();
    cyc();
    cyc();
    i_reset = 1'b0;

    push("rst_rs", 0);     check({24'b0, o_rs});
    push("rst_rt", 0);     check({24'b0, o_rt});
    push("rst_hz", 0);     check({31'b0, o_hazard});
    chk_pend("rst_pend", 16'h0);
    push("rst_busy", 0);   check({31'b0, o_busy});
    chk_err("rst_err", 1'b0);

    req_chk("special", 14, 15, 0, 0, 8'd4, 8'd2, 1'b0);
    chk_pend("special_pend", 16'h0);

    set_upd(3, M_CON, 8'h5A); cyc();
    req_chk("const_r3", 3, 0, 0, 0, 8'h5A, 8'h00, 1'b0);
    set_upd(14, M_CON, 8'h99); cyc();
    req_chk("ro_r14", 14, 3, 0, 0, 8'd4, 8'h5A, 1'b0);

    i_block_start = 1'b1; i_block_id = 8'd7; cyc();
    i_block_id = 8'd9; cyc();
    req_chk("blockidx", 13, 15, 0, 0, 8'd7, 8'd2, 1'b0);

    set_upd(5, M_MEM, 8'hFF); cyc();
    chk_pend("ldr_pend", 16'h0020);
    push("ldr_busy", 1); check({31'b0, o_busy});
    req_chk("ldr_haz", 5, 0, 0, 0, 8'h00, 8'h00, 1'b1);
    set_wb(5, 8'h33); cyc();
    chk_pend("wb_pend", 16'h0);
    req_chk("wb_read", 5, 0, 0, 0, 8'h33, 8'h00, 1'b0);

    set_upd(5, M_MEM, 8'h00); cyc();
    set_wb(5, 8'h44);
    req_chk("bypass", 5, 3, 0, 0, 8'h44, 8'h5A, 1'b0);
    chk_pend("bypass_pend", 16'h0);

    set_upd(7, M_MEM, 8'h00); cyc();
    req_chk("waw", 0, 0, 7, 1, 8'h00, 8'h00, 1'b1);
    set_wb(7, 8'h11); cyc();
    chk_err("legal_wb_err", 1'b0);

    set_wb(6, 8'h77); cyc();
    chk_err("bad_wb_err", 1'b1);
    cyc();
    chk_err("sticky_err", 1'b1);
    req_chk("r6_keep", 6, 7, 0, 0, 8'h00, 8'h11, 1'b0);
    set_wb(15, 8'h88); cyc();
    req_chk("r15_keep", 15, 0, 0, 0, 8'd2, 8'h00, 1'b0);

    set_upd(2, M_MEM, 8'h00); cyc();
    chk_pend("r2_pend", 16'h0004);
    i_reset = 1'b1; cyc(); i_reset = 1'b0;
    chk_pend("rst2_pend", 16'h0);
    chk_err("rst2_err", 1'b0);
    req_chk("rst2_ro", 13, 14, 0, 0, 8'd0, 8'd4, 1'b0);
    set_wb(2, 8'h55); cyc();
    chk_err("late_wb_err", 1'b1);
    req_chk("late_wb_r2", 2, 3, 0, 0, 8'h00, 8'h00, 1'b0);

    set_upd(4, M_MEM, 8'h00); cyc();
    set_upd(4, M_AR, 8'h10); set_wb(4, 8'h20); cyc();
    chk_pend("alu_wb_pend", 16'h0);
    req_chk("alu_wins", 4, 0, 0, 0, 8'h10, 8'h00, 1'b0);

    set_upd(8, M_MEM, 8'h00); cyc();
    set_upd(8, M_MEM, 8'h00); set_wb(8, 8'h66); cyc();
    chk_pend("mem_wb_pend", 16'h0100);
    req_chk("mem_wb", 8, 0, 0, 0, 8'h66, 8'h00, 1'b1);
    set_wb(8, 8'h67); cyc();
    chk_pend("mem_wb_clr", 16'h0);

    set_upd(9, M_MEM, 8'h00); cyc();
    set_upd(10, M_CON, 8'hAB); set_wb(9, 8'hCD); cyc();
    req_chk("two_ports", 9, 10, 0, 0, 8'hCD, 8'hAB, 1'b0);

    set_upd(11, M_MEM, 8'h00); cyc();
    chk_pend("r11_pend", 16'h0800);
    i_enable = 1'b0;
    set_upd(12, M_CON, 8'hEE); set_wb(11, 8'h12);
    i_block_start = 1'b1; i_block_id = 8'h3C;
    cyc();
    chk_pend("dis_pend", 16'h0800);
    push("dis_rs", 32'hCD); check({24'b0, o_rs});
    i_enable = 1'b0;
    i_core_state = REQ; i_rs_a = 4; i_rt_a = 4;
    cyc();
    push("dis_req_rs", 32'hCD); check({24'b0, o_rs});
    i_enable = 1'b1;
    req_chk("dis_regs", 12, 11, 0, 0, 8'h00, 8'h00, 1'b1);
    req_chk("dis_bidx", 13, 0, 0, 0, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
